imem_responder: RTL and testbench



---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_word_array.sv | 76 +++++++
 rtl/imem_responder.sv | 107 ++++++++++
 tb/tb_imem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder and its storage array.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/imem_word_array.sv
// Instruction storage: one program-load write port and one registered read capture
// that also records whether the address was misaligned or out of range.
module imem_word_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] ERR_DATA    = NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_capture,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_error
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_error_q, rd_error_d;
    logic [29:0]      wr_word, rd_word;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_in_range, rd_bad;
    logic             unused_wr_byte_bits;

    // Load writes are word-granular; the byte offset is deliberately dropped.
    assign unused_wr_byte_bits = ^wr_addr[1:0];

    always_comb begin
        wr_word     = word_index(wr_addr);
        rd_word     = word_index(rd_addr);
        wr_idx      = wr_word[IDX_W-1:0];
        rd_idx      = rd_word[IDX_W-1:0];
        wr_in_range = ({2'b00, wr_word} < 32'(DEPTH_WORDS));
        rd_bad      = (rd_addr[1:0] != 2'b00) || ({2'b00, rd_word} >= 32'(DEPTH_WORDS));
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_error_d = rd_error_q;
        if (rd_capture) begin
            if (rd_bad) begin
                rd_data_d  = ERR_DATA;
                rd_error_d = 1'b1;
            end else begin
                rd_data_d  = mem_q[rd_idx];
                rd_error_d = 1'b0;
            end
        end
    end

    // Storage is never cleared; reset only blocks a write on its own edge.
    always_ff @(posedge clock) begin
        if (reset && wr_en && wr_in_range) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_error_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_error_q <= rd_error_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_error = rd_error_q;

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for instruction fetch: accepts one request, waits a fixed
// number of cycles, then holds the response until the fetch stage takes it.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] ERR_DATA    = NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rd_addr;
    logic        enter_resp;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid, once raised, holds with its payload stable until that edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_addr    = addr_q;
        enter_resp = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                rd_addr   = req_addr;
                if (req_valid) begin
                    addr_d = req_addr;
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_CNT - 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    imem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ERR_DATA   (ERR_DATA)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (load_en),
        .wr_addr   (load_addr),
        .wr_data   (load_data),
        .rd_capture(enter_resp),
        .rd_addr   (rd_addr),
        .rd_data   (rsp_data),
        .rd_error  (rsp_error)
    );

    assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (two and zero wait states) checked
// against a word model and an expected-response queue per instance.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int          DEPTH    = 256;
    localparam logic [31:0] ERR_WORD = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_error [2];
    logic        load_en   [2];
    logic [31:0] load_addr [2];
    logic [31:0] load_data [2];
    logic [1:0]  dbg_state [2];

    logic [31:0] mem_m [2][DEPTH];
    logic [32:0] exp_q0 [$];
    logic [32:0] exp_q1 [$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .ERR_DATA(32'h0000_0013)) u_dut_ws2 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_error(rsp_error[0]), .load_en(load_en[0]), .load_addr(load_addr[0]),
        .load_data(load_data[0]), .dbg_state(dbg_state[0])
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .ERR_DATA(32'h0000_0013)) u_dut_ws0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_error(rsp_error[1]), .load_en(load_en[1]), .load_addr(load_addr[1]),
        .load_data(load_data[1]), .dbg_state(dbg_state[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] exp_of(input int d, input logic [31:0] a);
        if (a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH)) return {1'b1, ERR_WORD};
        return {1'b0, mem_m[d][a[9:2]]};
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic push(input int d, input logic [32:0] v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // Scoreboard: a response is consumed on the edge after a negedge with valid && ready.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (reset && rsp_valid[d] && rsp_ready[d]) begin
                if (q_size(d) == 0) begin
                    chk($sformatf("d%0d_unexpected_rsp", d), 32'(rsp_valid[d]), 32'd0);
                end else begin
                    logic [32:0] e;
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk($sformatf("d%0d_rsp_data", d), rsp_data[d], e[31:0]);
                    chk($sformatf("d%0d_rsp_error", d), 32'(rsp_error[d]), 32'(e[32]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int d, input logic [31:0] a, input logic [31:0] v);
        load_en[d]   = 1'b1;
        load_addr[d] = a;
        load_data[d] = v;
        tick();
        load_en[d] = 1'b0;
        if (a[31:2] < 30'(DEPTH)) mem_m[d][a[9:2]] = v;
    endtask

    task automatic send(input int d, input logic [31:0] a);
        logic acc;
        int   n;
        push(d, exp_of(d, a));
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clock);
            acc = req_ready[d];
            tick();
            n++;
        end
        req_valid[d] = 1'b0;
        if (!acc) chk($sformatf("d%0d_accept_timeout", d), 32'd0, 32'd1);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (q_size(d) != 0 && n < 200) begin
            tick();
            n++;
        end
        if (q_size(d) != 0) begin
            chk($sformatf("d%0d_drain_timeout", d), 32'(q_size(d)), 32'd0);
            if (d == 0) exp_q0.delete();
            else        exp_q1.delete();
        end
    endtask

    // Request presented in cycle 0; response valid in cycle ws+1, ready low until then.
    task automatic timed_req(input int d, input int ws, input logic [31:0] a);
        push(d, exp_of(d, a));
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        @(negedge clock);
        chk($sformatf("d%0d_t_acc_ready", d), 32'(req_ready[d]), 32'd1);
        tick();
        req_valid[d] = 1'b0;
        for (int i = 1; i <= ws + 1; i++) begin
            @(negedge clock);
            chk($sformatf("d%0d_t_req_ready_c%0d", d, i), 32'(req_ready[d]), 32'd0);
            chk($sformatf("d%0d_t_rsp_valid_c%0d", d, i), 32'(rsp_valid[d]), 32'(i == ws + 1));
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = '0;
            rsp_ready[d] = 1'b1;
            load_en[d]   = 1'b0;
            load_addr[d] = '0;
            load_data[d] = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("d%0d_rst_rsp_data", d), rsp_data[d], 32'd0);
            chk($sformatf("d%0d_rst_rsp_error", d), 32'(rsp_error[d]), 32'd0);
            chk($sformatf("d%0d_rst_state", d), 32'(dbg_state[d]), 32'(ST_IDLE));
        end
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("d0_rst_req_ready", 32'(req_ready[0]), 32'd1);
        chk("d1_rst_req_ready", 32'(req_ready[1]), 32'd1);
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            for (int d = 0; d < 2; d++) begin
                load_en[d]   = 1'b1;
                load_addr[d] = 32'(i * 4);
                load_data[d] = $urandom;
                mem_m[d][i]  = load_data[d];
            end
            tick();
        end
        load_en[0] = 1'b0;
        load_en[1] = 1'b0;

        // Two wait states: valid three cycles after the request cycle.
        load(0, 32'h0, 32'h0050_0093);
        timed_req(0, 2, 32'h0);
        @(negedge clock);
        chk("d0_t_ready_after", 32'(req_ready[0]), 32'd1);
        chk("d0_t_valid_after", 32'(rsp_valid[0]), 32'd0);
        tick();

        // Zero wait states, back-to-back at two-cycle spacing.
        load(1, 32'h0, 32'h1111_1111);
        load(1, 32'h4, 32'h2222_2222);
        timed_req(1, 0, 32'h0);
        timed_req(1, 0, 32'h4);
        @(negedge clock);
        chk("d1_t_ready_after", 32'(req_ready[1]), 32'd1);
        tick();

        // Backpressure: response held stable, competing request not accepted.
        load(0, 32'hC, 32'hCAFE_F00D);
        rsp_ready[0] = 1'b0;
        send(0, 32'hC);
        n = 0;
        @(negedge clock);
        while (!rsp_valid[0] && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("d0_bp_valid_seen", 32'(rsp_valid[0]), 32'd1);
        tick();
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("d0_bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
            chk("d0_bp_hold_data", rsp_data[0], 32'hCAFE_F00D);
            chk("d0_bp_hold_error", 32'(rsp_error[0]), 32'd0);
            chk("d0_bp_no_accept", 32'(req_ready[0]), 32'd0);
            tick();
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        tick();
        @(negedge clock);
        chk("d0_bp_valid_drop", 32'(rsp_valid[0]), 32'd0);
        chk("d0_bp_idle_ready", 32'(req_ready[0]), 32'd1);
        chk("d0_bp_idle_state", 32'(dbg_state[0]), 32'(ST_IDLE));
        chk("d0_bp_queue_empty", 32'(q_size(0)), 32'd0);
        tick();

        // Error and range boundaries, ignored out-of-range load, ignored byte offset.
        send(0, 32'h2);   drain(0);
        send(0, 32'h400); drain(0);
        send(0, 32'h3FC); drain(0);
        load(0, 32'h400, 32'hDEAD_BEEF);
        send(0, 32'h0);   drain(0);
        load(0, 32'h1D, 32'h1234_5678);
        send(0, 32'h1C);  drain(0);
        send(1, 32'h401); drain(1);

        // Load on the edge that enters RESP: the old word is returned.
        load(0, 32'h8, 32'h5555_5555);
        push(0, exp_of(0, 32'h8));
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8;
        @(negedge clock);
        chk("d0_rbw_acc_ready", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        tick();
        load_en[0]   = 1'b1;
        load_addr[0] = 32'h8;
        load_data[0] = 32'hAAAA_AAAA;
        tick();
        load_en[0]  = 1'b0;
        mem_m[0][2] = 32'hAAAA_AAAA;
        drain(0);
        send(0, 32'h8); drain(0);

        // Reset during WAIT: the in-flight request is dropped, storage survives.
        load(0, 32'h14, 32'h7777_7777);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h14;
        tick();
        req_valid[0] = 1'b0;
        @(negedge clock);
        chk("d0_rw_in_wait", 32'(dbg_state[0]), 32'(ST_WAIT));
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("d0_rw_valid", 32'(rsp_valid[0]), 32'd0);
            chk("d0_rw_data", rsp_data[0], 32'd0);
            chk("d0_rw_error", 32'(rsp_error[0]), 32'd0);
            chk("d0_rw_ready", 32'(req_ready[0]), 32'd1);
            tick();
        end
        send(0, 32'h14); drain(0);
        send(1, 32'h4);  drain(1);

        // Random requests and loads with random response backpressure.
        for (int k = 0; k < 40; k++) begin
            int          d;
            int          r;
            logic [31:0] a;
            d = k % 2;
            if ($urandom_range(0, 3) == 0) load(d, 32'($urandom_range(0, 255) * 4), $urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
            else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 1000) * 4);
            else             a = 32'($urandom_range(0, 255) * 4);
            send(d, a);
            n = 0;
            while (q_size(d) != 0 && n < 200) begin
                rsp_ready[d] = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            rsp_ready[d] = 1'b1;
            if (q_size(d) != 0) begin
                chk($sformatf("d%0d_rand_timeout", d), 32'(q_size(d)), 32'd0);
                if (d == 0) exp_q0.delete();
                else        exp_q1.delete();
            end
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
